conv_lut_quant: RTL and testbench
=================================

// Module: conv_lut_quant
// PURPOSE
//   Parametrised, pipelined requantisation LUT for the conv datapath: maps LANES
//   parallel IN_W-bit activations to OUT_W-bit codes through a runtime-programmable
//   table shared by all lanes. A truncate mode is also available.
//   Sits between the conv accumulator/bit-slice stage and the packed-activation
//   writer. Uses a valid/ready stream on both sides.
//   Table reset contents reproduce the fixed MSB-threshold mapping: code 1 iff the input MSB is set.
// PARAMETERS
//   LANES  4  parallel lanes per beat
//   IN_W   4  input bits per lane; table depth = 2**IN_W
//   OUT_W  2  output bits per lane; must satisfy 1 <= OUT_W <= IN_W
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous reset, active-high
//   in_valid   in   1            input beat valid
//   in_ready   out  1            input beat accepted when in_valid & in_ready
//   in_data    in   LANES*IN_W   lane k is in_data[k*IN_W +: IN_W]
//   in_mode    in   1            0 = LUT lookup, 1 = truncate (top OUT_W bits); travels with the beat
//   out_valid  out  1            output beat valid
//   out_ready  in   1            downstream accept
//   out_data   out  LANES*OUT_W  lane k is out_data[k*OUT_W +: OUT_W]
//   cfg_we     in   1            table write strobe
//   cfg_addr   in   IN_W         table entry index
//   cfg_data   in   OUT_W        table entry value
// BEHAVIOUR
//   Pipeline structure
//     S1 registers {in_data, in_mode}. S2 registers the looked-up or truncated result.
//     out_valid/out_data are the S2 registers.
//   Stall and handshake
//     stall = out_valid & ~out_ready. in_ready = ~stall (combinational).
//     When not stalled, S1 loads the input beat (S1 valid = in_valid & in_ready) and S2 loads from S1.
//     When stalled, S1 and S2 hold. A bubble in S1 is not collapsed during a stall.
//     out_data is held stable while out_valid & ~out_ready.
//   Latency and throughput
//     Latency is 2 cycles: a beat accepted on edge N appears on out_valid after edge N+1.
//     Throughput is 1 beat/cycle when out_ready is held high. Beat order is preserved.
//   Lookup
//     Mode 0: each lane is looked up independently, out lane = table[in lane].
//     Mode 1: out lane = in lane[IN_W-1 -: OUT_W].
//   Table
//     2**IN_W x OUT_W flip-flops. On reset, entry i = {{(OUT_W-1){1'b0}}, i[IN_W-1]}.
//     cfg_we writes table[cfg_addr] = cfg_data at the clock edge. A write is accepted in any cycle, including during a stall.
//     Simultaneous write and S1->S2 lookup of the same entry: the lookup uses the OLD value.
//     The new value is visible to lookups from the next cycle.
//     A stalled S2 never re-reads the table; its held data does not change after a write.
//   Reset values
//     in_ready = 1 while not stalled (S2 empty after reset). out_valid = 0. out_data = 0.
//     S1 valid = 0. Table = default.
//   Reset mid-operation
//     All in-flight beats are dropped: out_valid = 0 on the cycle after rst.
//     Table contents are restored to the default; programmed entries are lost.
//     in_valid and cfg_we are ignored while rst = 1.
// TESTING
//   1. After reset, mode 0, lanes {0x7,0x8,0x0,0xF}, out_ready=1 -> out lanes {0,1,0,1}
//      with out_valid exactly 2 cycles after acceptance.
//   2. Write table[3]=2'b11, then send lane 0x3 -> 2'b11.
//      Issue the write on the same edge as the S1->S2 lookup of 0x3 -> 2'b00 (old value);
//      the next beat with 0x3 -> 2'b11.
//   3. Stream 8 beats while out_ready is low for 5 cycles mid-stream ->
//      in_ready=0 whenever out_valid & ~out_ready; out_data is stable;
//      all 8 outputs appear in order with no loss or duplication.
//   4. Mode 1, lanes {0xB,0x4,0xF,0x1} -> {2'b10,2'b01,2'b11,2'b00}.
//      Interleave mode 0/1 beats back-to-back; each beat uses its own mode.
//   5. Program table[3]=2'b11 and table[9]=2'b00, then assert rst with 2 beats in flight ->
//      out_valid=0 the next cycle; 0x3 then maps to 0 and 0x9 maps to 1.
//   6. 16 beats with lane values 0..15 on consecutive cycles, out_ready=1 ->
//      16 consecutive out_valid cycles with values matching the table model.

Source files
------------

// File: rtl/conv_lut_quant.sv
`default_nettype none
// ============================================================================
//  Module      : conv_lut_quant
//  Description : Two-stage requantisation pipeline for the conv datapath.
//                Maps LANES parallel IN_W-bit activations to OUT_W-bit codes,
//                either through a shared runtime-programmable table (mode 0)
//                or by keeping the top OUT_W bits of each lane (mode 1).
//                Valid/ready on both sides; back-pressure stalls both stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_lut_quant #(
    parameter int LANES = 4,
    parameter int IN_W  = 4,
    parameter int OUT_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic                   in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    input  logic                   cfg_we,
    input  logic [IN_W-1:0]        cfg_addr,
    input  logic [OUT_W-1:0]       cfg_data
);

    localparam int c_DEPTH = 2**IN_W;

    // Shared lookup table, one OUT_W-bit entry per possible input code
    logic [OUT_W-1:0]       r_table [c_DEPTH];

    // Stage 1: captured input beat and its mode
    logic                   r_s1_valid;
    logic [LANES*IN_W-1:0]  r_s1_data;
    logic                   r_s1_mode;

    // Stage 2: result registers, driven straight onto the output port
    logic                   r_out_valid;
    logic [LANES*OUT_W-1:0] r_out_data;

    logic                   w_stall;
    logic [LANES*OUT_W-1:0] w_lookup;

    // A full output stage that is not being drained freezes the whole pipe
    assign w_stall   = r_out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Per-lane result: table entry or top OUT_W bits of the lane, by beat mode
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [IN_W-1:0] w_lane_in;
            assign w_lane_in = r_s1_data[k*IN_W +: IN_W];
            assign w_lookup[k*OUT_W +: OUT_W] = r_s1_mode ? w_lane_in[IN_W-1 -: OUT_W]
                                                          : r_table[w_lane_in];
        end
    endgenerate

    // Table storage: reset restores the MSB-threshold map (code 1 iff MSB set);
    // a write lands at the edge, so a lookup on the same edge sees the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_table[i] <= OUT_W'(i >> (IN_W-1));
            end
        end else if (cfg_we) begin
            r_table[cfg_addr] <= cfg_data;
        end
    end

    // Pipeline advance: both stages move together or hold together; a stalled
    // output stage keeps its data and never re-reads the table
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_mode   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (!w_stall) begin
            r_s1_valid  <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
                r_s1_mode <= in_mode;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_lookup;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_lut_quant.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_lut_quant
//  Description : Self-checking bench for conv_lut_quant. A transaction-level
//                reference (table array + queue of expected output beats)
//                is compared against the DUT every cycle; directed sections
//                pin the reference with hand-computed literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_lut_quant;

    localparam int LANES = 4;
    localparam int IN_W  = 4;
    localparam int OUT_W = 2;
    localparam int DEPTH = 1 << IN_W;
    localparam int DW_IN  = LANES*IN_W;
    localparam int DW_OUT = LANES*OUT_W;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic              in_mode   = 1'b0;
    logic              out_ready = 1'b1;
    logic              cfg_we    = 1'b0;
    logic [DW_IN-1:0]  in_data   = '0;
    logic [IN_W-1:0]   cfg_addr  = '0;
    logic [OUT_W-1:0]  cfg_data  = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DW_OUT-1:0] out_data;

    int checks = 0;
    int errors = 0;
    int fires  = 0;

    // Reference state: table contents and expected output beats in order
    logic [OUT_W-1:0]  m_tbl [DEPTH];
    logic [DW_OUT-1:0] exp_q [$];
    logic [DW_OUT-1:0] dummy;

    bit                edge_rst;
    bit                edge_stall;
    logic [DW_OUT-1:0] edge_data;

    logic              t4_mode [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [DW_OUT-1:0] t4_exp  [4] = '{8'h36, 8'h11, 8'h36, 8'h11};

    always #5 clk = ~clk;

    conv_lut_quant #(
        .LANES (LANES),
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected output beat for an input beat, given the table as it is now
    function automatic logic [DW_OUT-1:0] model(input logic [DW_IN-1:0] d, input logic m);
        logic [DW_OUT-1:0] r;
        int v;
        int code;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            v = int'(d[k*IN_W +: IN_W]);
            if (m) code = v / (1 << (IN_W - OUT_W));
            else   code = int'(m_tbl[v]);
            r[k*OUT_W +: OUT_W] = OUT_W'(code);
        end
        return r;
    endfunction

    // Scoreboard update at the edge, then compare just after the edge
    always @(posedge clk) begin
        edge_rst   = rst;
        edge_stall = out_valid && !out_ready;
        edge_data  = out_data;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) m_tbl[i] = (i >= DEPTH/2) ? OUT_W'(1) : OUT_W'(0);
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) dummy = exp_q.pop_front();
                fires++;
            end
            if (cfg_we) m_tbl[cfg_addr] = cfg_data;
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_mode));
        end
        #1;
        if (edge_rst) begin
            chk("reset_out_valid", out_valid, 0);
        end else if (edge_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, edge_data);
        end
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (out_valid && !edge_rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_order: got 0x%0h, expected no beat", out_data);
            end else begin
                chk("out_data", out_data, exp_q[0]);
            end
        end
    end

    initial begin
        logic             acc;
        int               sent;
        int               c;
        int               fires0;
        int               run;
        int               best;
        logic [DW_IN-1:0] cur_data;
        logic             cur_mode;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);

        // Default table, two-cycle latency
        in_valid = 1'b1; in_data = 16'hF087; in_mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_not_yet", out_valid, 0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 8'h44);
        @(negedge clk);
        chk("t1_single", out_valid, 0);

        // Write colliding with the lookup of the same entry
        in_valid = 1'b1; in_data = 16'h3333;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 2'b11;
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        chk("t2_old_valid", out_valid, 1);
        chk("t2_old_value", out_data, 8'h00);
        @(negedge clk);
        chk("t2_new_valid", out_valid, 1);
        chk("t2_new_value", out_data, 8'hFF);
        in_valid = 1'b1; in_data = 16'h0003;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_written", out_data, 8'h03);
        @(negedge clk);

        // Eight beats through a five-cycle back-pressure window
        sent = 0; c = 0; fires0 = fires;
        cur_data = DW_IN'($urandom); cur_mode = 1'($urandom_range(0, 1));
        while ((sent < 8 || c < 12) && c < 60) begin
            out_ready = !(c >= 3 && c < 8);
            in_valid  = (sent < 8);
            in_data   = cur_data;
            in_mode   = cur_mode;
            #1 acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) begin
                sent++;
                cur_data = DW_IN'($urandom);
                cur_mode = 1'($urandom_range(0, 1));
            end
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_sent", sent, 8);
        chk("t3_delivered", fires - fires0, 8);

        // Truncate mode and back-to-back mode interleave
        for (int j = 0; j < 6; j++) begin
            if (j >= 2) begin
                chk("t4_valid", out_valid, 1);
                chk("t4_data", out_data, t4_exp[j-2]);
            end
            if (j < 4) begin
                in_valid = 1'b1; in_data = 16'h1F4B; in_mode = t4_mode[j];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_mode = 1'b0;

        // Reset with two beats in flight restores the default table
        cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = 2'b00;
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b1; in_data = 16'h9393;
        @(negedge clk);
        @(negedge clk);
        chk("t5_programmed", out_data, 8'h33);
        rst = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = 2'b11;
        @(negedge clk);
        chk("t5_flush", out_valid, 0);
        rst = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t5_no_ghost", out_valid, 0);
        in_valid = 1'b1; in_data = 16'h9393;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_default_valid", out_valid, 1);
        chk("t5_default_data", out_data, 8'h44);
        @(negedge clk);

        // Sixteen consecutive beats through a partly reprogrammed table
        for (int w = 0; w < 4; w++) begin
            cfg_we = 1'b1; cfg_addr = IN_W'($urandom); cfg_data = OUT_W'($urandom);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        run = 0; best = 0;
        for (int j = 0; j < 20; j++) begin
            if (j < 16) begin
                in_valid = 1'b1; in_data = {4{4'(j)}}; in_mode = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) run++;
            else run = 0;
            if (run > best) best = run;
        end
        chk("t6_run", best, 16);

        // Randomised traffic; table reprogrammed only while the pipe is empty
        for (int r = 0; r < 6; r++) begin
            in_valid = 1'b0; out_ready = 1'b1;
            repeat (3) @(negedge clk);
            for (int w = 0; w < 4; w++) begin
                cfg_we = 1'b1; cfg_addr = IN_W'($urandom); cfg_data = OUT_W'($urandom);
                @(negedge clk);
            end
            cfg_we = 1'b0;
            for (int k = 0; k < 150; k++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = DW_IN'($urandom);
                in_mode   = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
